// File: rtl/simple_pkg.sv
// Shared definitions for the SIMPLE pipeline: default widths, the bubble
// instruction and the fetch queue entry layout.
package simple_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 16;
  localparam int unsigned INST_W_DEFAULT = 16;

  // Decoded by ctl as no register write and no branch.
  localparam logic [15:0] BUBBLE_INST = 16'h0000;

  typedef struct packed {
    logic [INST_W_DEFAULT-1:0] inst;
    logic [ADDR_W_DEFAULT-1:0] pc_plus1;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small power-of-two FIFO holding fetched words between the instruction RAM
// and the IF/ID register. Flush dominates push; pop of an empty queue is ignored.
module fetch_queue #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [WIDTH-1:0]             head_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_en, pop_en;

  // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is 2^n).
  always_comb begin
    push_en  = push && !flush;
    pop_en   = pop && !flush && (count_q != '0);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_en);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_en);
    count_d  = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the instruction RAM address, absorbs its
// one-cycle read latency and buffers words so ID stalls never lose one.
// Optional macro FETCH_PERF_EN adds saturating fetch/bubble counters.
module fetch_unit
  import simple_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned INST_W = INST_W_DEFAULT,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] ir_out,
  output logic [ADDR_W-1:0] ir_pc_plus1,
  output logic              ir_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       perf_fetch_cnt,
  output logic [15:0]       perf_bubble_cnt
`endif
);

  localparam int unsigned CNT_W   = $clog2(DEPTH+1);
  localparam int unsigned ENTRY_W = INST_W + ADDR_W;

  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]  req_pc1_q, req_pc1_d;
  logic               inflight_q, inflight_d;
  logic               epoch_q, epoch_d;
  logic               req_epoch_q, req_epoch_d;

  logic [CNT_W-1:0]   count;
  logic [CNT_W:0]     occupancy;
  logic [ENTRY_W-1:0] head_data;
  logic               arrival, pop, issue;

  fetch_queue #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (arrival),
    .push_data ({imem_rdata, req_pc1_q}),
    .pop       (pop),
    .count     (count),
    .head_data (head_data)
  );

  // Issue decision, epoch kill and PC sequencing.
  always_comb begin
    // A read tagged with a stale epoch belongs to a flushed path.
    arrival     = inflight_q && (req_epoch_q == epoch_q);
    pop         = ir_valid && !stall;
    // Slots committed after this edge: held entries plus the returning read.
    occupancy   = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
    issue       = run && !redirect && (occupancy < (CNT_W+1)'(DEPTH));

    fetch_pc_d  = fetch_pc_q;
    req_pc1_d   = req_pc1_q;
    req_epoch_d = req_epoch_q;
    inflight_d  = issue;
    epoch_d     = epoch_q ^ redirect;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
    end else if (issue) begin
      fetch_pc_d  = fetch_pc_q + 1'b1;
      req_pc1_d   = fetch_pc_q + 1'b1;
      req_epoch_d = epoch_q;
    end
  end

  // Fetch state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q  <= '0;
      req_pc1_q   <= '0;
      inflight_q  <= 1'b0;
      epoch_q     <= 1'b0;
      req_epoch_q <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      req_pc1_q   <= req_pc1_d;
      inflight_q  <= inflight_d;
      epoch_q     <= epoch_d;
      req_epoch_q <= req_epoch_d;
    end
  end

  // Head presentation; an empty queue shows a bubble with a zero PC+1.
  always_comb begin
    imem_addr   = fetch_pc_q;
    ir_valid    = (count != '0);
    ir_out      = INST_W'(BUBBLE_INST);
    ir_pc_plus1 = '0;
    if (ir_valid) begin
      ir_out      = head_data[ENTRY_W-1:ADDR_W];
      ir_pc_plus1 = head_data[ADDR_W-1:0];
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating counters: accepted pushes and run cycles with no valid head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (arrival && !redirect && (perf_fetch_cnt != 16'hFFFF)) begin
        perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
      end
      if (!ir_valid && run && (perf_bubble_cnt != 16'hFFFF)) begin
        perf_bubble_cnt <= perf_bubble_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, async reset check and a random
// phase checked against an instruction-stream model.
module tb_fetch_unit;
  import simple_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n, run, stall, redirect;
  logic [15:0] redirect_pc, imem_addr, imem_rdata, ir_out, ir_pc_plus1;
  logic        ir_valid;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetch_cnt, perf_bubble_cnt;
`endif

  logic [15:0] mem [65536];

  fetch_unit #(
    .ADDR_W (16),
    .INST_W (16),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .ir_out      (ir_out),
    .ir_pc_plus1 (ir_pc_plus1),
    .ir_valid    (ir_valid)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous instruction RAM, one cycle read latency.
  always @(posedge clk) imem_rdata <= mem[imem_addr];

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    bit           restart;
    bit           run;
    bit           stall;
    bit           redirect;
    logic [15:0]  rpc;
    bit           exp_valid;
    fetch_entry_t exp_head;
    logic [15:0]  exp_addr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit rs, bit rn, bit st, bit rd, logic [15:0] rpc, bit v,
                              logic [15:0] inst, logic [15:0] pc1, logic [15:0] addr);
    vec_t t;
    t.restart = rs; t.run = rn; t.stall = st; t.redirect = rd; t.rpc = rpc;
    t.exp_valid = v; t.exp_head.inst = inst; t.exp_head.pc_plus1 = pc1; t.exp_addr = addr;
    vecs.push_back(t);
  endfunction

  // Asserts reset for two edges and releases it just after a rising edge.
  task automatic do_reset();
    run = 0; stall = 0; redirect = 0; redirect_pc = '0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  logic [15:0] exp_pc;
  logic [15:0] ahead;
  int unsigned streak;
  int unsigned bub_model;

  initial begin
    rst_n = 0; run = 0; stall = 0; redirect = 0; redirect_pc = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[16'h0000] = 16'hA001; mem[16'h0001] = 16'hA002;
    mem[16'h0002] = 16'hA003; mem[16'h0003] = 16'hA004;
    mem[16'h0040] = 16'hC040; mem[16'h0041] = 16'hC041; mem[16'h0042] = 16'hC042;
    mem[16'h0080] = 16'hC080; mem[16'hFFFF] = 16'hB00B;

    // Stall for 3 cycles with A002 at the head.
    add(1,1,0,0,16'h0,   0,16'h0000,16'h0000,16'h0000);
    add(0,1,0,0,16'h0,   0,16'h0000,16'h0000,16'h0001);
    add(0,1,0,0,16'h0,   1,16'hA001,16'h0001,16'h0002);
    add(0,1,1,0,16'h0,   1,16'hA002,16'h0002,16'h0003);
    add(0,1,1,0,16'h0,   1,16'hA002,16'h0002,16'h0003);
    add(0,1,1,0,16'h0,   1,16'hA002,16'h0002,16'h0003);
    add(0,1,0,0,16'h0,   1,16'hA002,16'h0002,16'h0003);
    add(0,1,0,0,16'h0,   1,16'hA003,16'h0003,16'h0004);
    add(0,1,0,0,16'h0,   1,16'hA004,16'h0004,16'h0005);
    // Redirect while A003 is in flight, then redirect together with stall.
    add(1,1,0,0,16'h0,   0,16'h0000,16'h0000,16'h0000);
    add(0,1,0,0,16'h0,   0,16'h0000,16'h0000,16'h0001);
    add(0,1,0,0,16'h0,   1,16'hA001,16'h0001,16'h0002);
    add(0,1,0,1,16'h0040,1,16'hA002,16'h0002,16'h0003);
    add(0,1,0,0,16'h0,   0,16'h0000,16'h0000,16'h0040);
    add(0,1,0,0,16'h0,   0,16'h0000,16'h0000,16'h0041);
    add(0,1,0,0,16'h0,   1,16'hC040,16'h0041,16'h0042);
    add(0,1,0,0,16'h0,   1,16'hC041,16'h0042,16'h0043);
    add(0,1,1,1,16'h0080,1,16'hC042,16'h0043,16'h0044);
    add(0,1,0,0,16'h0,   0,16'h0000,16'h0000,16'h0080);
    add(0,1,0,0,16'h0,   0,16'h0000,16'h0000,16'h0081);
    add(0,1,0,0,16'h0,   1,16'hC080,16'h0081,16'h0082);
    // Address wrap from FFFF to 0.
    add(1,1,0,1,16'hFFFF,0,16'h0000,16'h0000,16'h0000);
    add(0,1,0,0,16'h0,   0,16'h0000,16'h0000,16'hFFFF);
    add(0,1,0,0,16'h0,   0,16'h0000,16'h0000,16'h0000);
    add(0,1,0,0,16'h0,   1,16'hB00B,16'h0000,16'h0001);
    add(0,1,0,0,16'h0,   1,16'hA001,16'h0001,16'h0002);
    // run dropped mid-stream: in-flight word still delivered.
    add(1,1,0,0,16'h0,   0,16'h0000,16'h0000,16'h0000);
    add(0,1,0,0,16'h0,   0,16'h0000,16'h0000,16'h0001);
    add(0,1,0,0,16'h0,   1,16'hA001,16'h0001,16'h0002);
    add(0,0,0,0,16'h0,   1,16'hA002,16'h0002,16'h0003);
    add(0,0,0,0,16'h0,   1,16'hA003,16'h0003,16'h0003);
    add(0,0,0,0,16'h0,   0,16'h0000,16'h0000,16'h0003);
    add(0,0,0,0,16'h0,   0,16'h0000,16'h0000,16'h0003);

    // Reset state while rst_n is held low.
    @(negedge clk);
    check("reset_valid", ir_valid, 0);
    check("reset_ir", ir_out, BUBBLE_INST);
    check("reset_pc1", ir_pc_plus1, 0);
    check("reset_addr", imem_addr, 0);

    foreach (vecs[i]) begin
      if (vecs[i].restart) do_reset();
      run = vecs[i].run; stall = vecs[i].stall;
      redirect = vecs[i].redirect; redirect_pc = vecs[i].rpc;
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), ir_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_ir", i), ir_out, vecs[i].exp_head.inst);
      check($sformatf("vec%0d_pc1", i), ir_pc_plus1, vecs[i].exp_head.pc_plus1);
      check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
      @(posedge clk); #1;
    end

    // Asynchronous reset mid-stall, away from any clock edge.
    do_reset();
    run = 1;
    repeat (4) @(posedge clk);
    #1 stall = 1;
    repeat (3) @(posedge clk);
    #3;
    check("pre_areset_valid", ir_valid, 1);
    rst_n = 0;
    #1;
    check("areset_valid", ir_valid, 0);
    check("areset_ir", ir_out, BUBBLE_INST);
    check("areset_pc1", ir_pc_plus1, 0);
    check("areset_addr", imem_addr, 0);

    // Random phase against the instruction-stream model.
    do_reset();
    exp_pc = '0; streak = 0; bub_model = 0;
    for (int c = 0; c < 3000; c++) begin
      run      = ($urandom_range(0, 7) != 0);
      stall    = ($urandom_range(0, 3) == 0);
      redirect = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_pc = 16'hFFFE;
        1:       redirect_pc = 16'hFFFF;
        default: redirect_pc = 16'($urandom);
      endcase
      @(negedge clk);
      if (ir_valid) begin
        check("rand_ir", ir_out, mem[exp_pc]);
        check("rand_pc1", ir_pc_plus1, 16'(exp_pc + 16'd1));
      end else begin
        check("rand_bubble_ir", ir_out, BUBBLE_INST);
        check("rand_bubble_pc1", ir_pc_plus1, 0);
      end
      ahead = imem_addr - exp_pc;
      check("rand_fetch_ahead", (ahead <= 16'(DEPTH)), 1);
      if (!ir_valid && run && bub_model < 16'hFFFF) bub_model++;
      if (redirect || !run || ir_valid) streak = 0;
      else streak++;
      check("rand_bubble_bound", (streak <= 2), 1);
      if (redirect) exp_pc = redirect_pc;
      else if (ir_valid && !stall) exp_pc = 16'(exp_pc + 16'd1);
      @(posedge clk); #1;
    end
`ifdef FETCH_PERF_EN
    check("perf_bubble_cnt", perf_bubble_cnt, bub_model);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
